dac_wr_sched: RTL and testbench

//  Sequencer and arbiter in front of the single-channel SPI DAC writer (strw/din/eow handshake).
//  - Generates a periodic sample stream from an external synchronous waveform LUT.
//  - Merges it with sporadic configuration writes from a host requester.
//  - Issues one write at a time and waits for end-of-write before the next.

---
 rtl/dac_wr_sched.sv | 108 ++++++++++
 tb/tb_dac_wr_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wr_sched.sv
// Write sequencer/arbiter in front of a single-channel SPI DAC writer: periodic LUT stream plus host config writes.
// Optional saturating miss counter output miss_cnt_o when DAC_WR_MISS_CNT_EN is defined.
module dac_wr_sched #(
  parameter int         AW  = 8,
  parameter logic [3:0] CMD = 4'h3,
  parameter int         PW  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [PW-1:0] period_i,
  output logic [AW-1:0] lut_addr_o,
  input  logic [11:0]   lut_data_i,
  input  logic          cfg_req_i,
  input  logic [15:0]   cfg_data_i,
  output logic          cfg_ack_o,
  output logic          strw_o,
  output logic [15:0]   din_o,
  input  logic          eow_i,
  output logic          busy_o,
  output logic          miss_o
`ifdef DAC_WR_MISS_CNT_EN
  ,
  output logic [7:0]    miss_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] timer_q, timer_d, pm1;
  logic          spend_q, spend_d;
  logic          last_cfg_q, last_cfg_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   load_word;
  logic          tick, grant_s, grant_c, load_go;

  // last_cfg_q doubles as the type of the transfer in flight, since it is updated on every grant
  assign pm1     = (period_i < PW'(2)) ? PW'(1) : period_i - PW'(1);
  assign tick    = en_i & (timer_q >= pm1);
  assign grant_c = (state_q == S_IDLE) & cfg_req_i & (~spend_q | ~last_cfg_q);
  assign grant_s = (state_q == S_IDLE) & spend_q & (~cfg_req_i | last_cfg_q);
  assign load_go = (state_q == S_LOAD) & (~last_cfg_q | cfg_req_i);
  assign load_word = last_cfg_q ? cfg_data_i : {CMD, lut_data_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      spend_q    <= 1'b0;
      last_cfg_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      spend_q    <= spend_d;
      last_cfg_q <= last_cfg_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_s) state_d = S_FETCH;
               else if (grant_c) state_d = S_LOAD;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = load_go ? S_WAIT : S_IDLE;
      S_WAIT:  if (eow_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d    = (!en_i || tick) ? '0 : timer_q + PW'(1);
    spend_d    = spend_q;
    last_cfg_d = last_cfg_q;
    if (!en_i)        spend_d = 1'b0;
    else if (tick)    spend_d = 1'b1;
    else if (grant_s) spend_d = 1'b0;
    if (grant_c)      last_cfg_d = 1'b1;
    else if (grant_s) last_cfg_d = 1'b0;
    addr_d     = (load_go && !last_cfg_q) ? addr_q + AW'(1) : addr_q;
    din_d      = load_go ? load_word : din_q;
    // din_o bypasses the register during LOAD so the word is valid alongside strw_o
    din_o      = din_d;
    strw_o     = load_go;
    cfg_ack_o  = load_go & last_cfg_q;
    busy_o     = (state_q != S_IDLE);
    miss_o     = tick & spend_q;
    lut_addr_o = addr_q;
  end

`ifdef DAC_WR_MISS_CNT_EN
  logic [7:0] miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miss_cnt_q <= '0;
    else if (miss_o && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
  end

  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dac_wr_sched.sv
// Bench for dac_wr_sched: transaction-level model compared every cycle plus directed literal checks.
module tb_dac_wr_sched;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [15:0] period_i = 16'd100;
  logic [7:0]  lut_addr_o;
  logic [11:0] lut_data_i = '0;
  logic        cfg_req_i = 1'b0;
  logic [15:0] cfg_data_i = '0;
  logic        cfg_ack_o, strw_o, busy_o, miss_o;
  logic [15:0] din_o;
  logic        eow_i = 1'b0;
`ifdef DAC_WR_MISS_CNT_EN
  logic [7:0]  miss_cnt_o;
`endif

  int tests = 0;
  int fails = 0;
  int eow_delay = 20;
  int eow_cnt = 0;
  int strw_seen = 0, eow_seen = 0, miss_seen = 0;

  dac_wr_sched dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .period_i(period_i),
    .lut_addr_o(lut_addr_o), .lut_data_i(lut_data_i),
    .cfg_req_i(cfg_req_i), .cfg_data_i(cfg_data_i), .cfg_ack_o(cfg_ack_o),
    .strw_o(strw_o), .din_o(din_o), .eow_i(eow_i), .busy_o(busy_o),
    .miss_o(miss_o)
`ifdef DAC_WR_MISS_CNT_EN
    , .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // synchronous LUT holding a*4
  always @(posedge clk) lut_data_i <= 12'(int'(lut_addr_o) * 4);

  // SPI writer stand-in: eow_i pulse eow_delay cycles after each strw_o
  always @(negedge clk) begin
    if (eow_cnt > 1) begin
      eow_cnt <= eow_cnt - 1;
      eow_i   <= 1'b0;
    end else if (eow_cnt == 1) begin
      eow_cnt <= 0;
      eow_i   <= 1'b1;
    end else begin
      eow_i   <= 1'b0;
    end
    if (strw_o === 1'b1) eow_cnt <= eow_delay;
  end

  always @(posedge clk) begin
    if (strw_o === 1'b1) strw_seen <= strw_seen + 1;
    if (eow_i && busy_o === 1'b1) eow_seen <= eow_seen + 1;
    if (miss_o === 1'b1) miss_seen <= miss_seen + 1;
  end

  // Transaction model: age counts cycles since the grant of the transfer in flight
  typedef struct packed {
    int        cnt;
    bit        sp;
    bit        infl;
    bit        iscfg;
    int        age;
    bit        sent;
    bit [7:0]  addr;
    bit        lastcfg;
    bit [15:0] din;
  } mst_t;

  mst_t m;

  function automatic int eff_period();
    return (period_i < 16'd2) ? 2 : int'(period_i);
  endfunction

  function automatic bit m_tick(mst_t s);
    return en_i && (s.cnt >= eff_period() - 1);
  endfunction

  function automatic bit [15:0] m_word(mst_t s);
    return s.iscfg ? cfg_data_i : {4'h3, 12'(int'(s.addr) * 4)};
  endfunction

  function automatic bit m_strw(mst_t s);
    return s.infl && !s.sent && (s.age == (s.iscfg ? 1 : 2)) && (!s.iscfg || cfg_req_i);
  endfunction

  function automatic mst_t m_step(mst_t s);
    mst_t n = s;
    bit tk = m_tick(s);
    bit pick_cfg = 1'b0;
    bit gs = 1'b0;
    n.cnt = (!en_i || tk) ? 0 : s.cnt + 1;
    if (!s.infl) begin
      if (s.sp || cfg_req_i) begin
        pick_cfg  = (s.sp && cfg_req_i) ? !s.lastcfg : cfg_req_i;
        gs        = !pick_cfg;
        n.infl    = 1'b1;
        n.iscfg   = pick_cfg;
        n.lastcfg = pick_cfg;
        n.age     = 1;
        n.sent    = 1'b0;
      end
    end else begin
      n.age = s.age + 1;
      if (m_strw(s)) begin
        n.sent = 1'b1;
        n.din  = m_word(s);
        if (!s.iscfg) n.addr = s.addr + 8'd1;
      end else if (!s.sent && s.iscfg && s.age == 1) begin
        n.infl = 1'b0;
      end else if (s.sent && eow_i) begin
        n.infl = 1'b0;
      end
    end
    n.sp = !en_i ? 1'b0 : tk ? 1'b1 : gs ? 1'b0 : s.sp;
    return n;
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) m <= '0;
    else       m <= m_step(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    bit e_strw;
    forever begin
      @(negedge clk);
      e_strw = m_strw(m);
      chk("strw_o", 32'(strw_o), 32'(e_strw));
      chk("cfg_ack_o", 32'(cfg_ack_o), 32'(e_strw && m.iscfg));
      chk("din_o", 32'(din_o), 32'(e_strw ? m_word(m) : m.din));
      chk("busy_o", 32'(busy_o), 32'(m.infl));
      chk("miss_o", 32'(miss_o), 32'(m_tick(m) && m.sp));
      chk("lut_addr_o", 32'(lut_addr_o), 32'(m.addr));
    end
  endtask

  task automatic wait_strw(input int limit, output int n);
    bit found = 1'b0;
    n = limit;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (strw_o === 1'b1) begin
        found = 1'b1;
        n = i;
        break;
      end
    end
    chk("strw_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(found), 32'd1);
  endtask

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, m0, s0, e0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_strw", 32'(strw_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_addr", 32'(lut_addr_o), 32'd0);
    chk("rst_din", 32'(din_o), 32'd0);
    chk("rst_ack", 32'(cfg_ack_o), 32'd0);
    fork
      compare_loop();
    join_none

    // config write with stream disabled
    drive_step();
    cfg_data_i = 16'hA5C3;
    cfg_req_i  = 1'b1;
    eow_delay  = 5;
    wait_strw(10, n);
    chk("cfg_latency", 32'(n), 32'd1);
    chk("cfg_ack", 32'(cfg_ack_o), 32'd1);
    chk("cfg_din", 32'(din_o), 32'hA5C3);
    drive_step();
    cfg_req_i = 1'b0;
    wait_idle(20);

    // stream, period 100, full address wrap
    drive_step();
    period_i  = 16'd100;
    eow_delay = 20;
    en_i      = 1'b1;
    m0        = miss_seen;
    wait_strw(200, n);
    chk("stream_first_latency", 32'(n), 32'd102);
    chk("stream_din0", 32'(din_o), 32'h3000);
    for (int k = 1; k <= 256; k++) begin
      wait_strw(200, n);
      chk("stream_interval", 32'(n), 32'd99);
      chk("stream_din", 32'(din_o), 32'(16'h3000 | 16'((k % 256) * 4)));
      if (k == 255) chk("stream_din_last", 32'(din_o), 32'h33FC);
      if (k == 256) chk("stream_din_wrap", 32'(din_o), 32'h3000);
    end
    chk("stream_no_miss", 32'(miss_seen - m0), 32'd0);
    drive_step();
    en_i = 1'b0;
    wait_idle(50);

    // overload: period 10, writes take 30 cycles
    drive_step();
    period_i  = 16'd10;
    eow_delay = 30;
    en_i      = 1'b1;
    m0 = miss_seen;
    s0 = strw_seen;
    e0 = eow_seen;
    repeat (300) @(posedge clk);
    #1 en_i = 1'b0;
    wait_idle(100);
    repeat (2) @(posedge clk);
    #1;
    chk("overload_miss", 32'(miss_seen - m0 > 0), 32'd1);
    chk("overload_eow", 32'(eow_seen - e0), 32'(strw_seen - s0));

    // period 0 acts as 2; one long write forces many misses
    drive_step();
    period_i  = 16'd0;
    eow_delay = 700;
    en_i      = 1'b1;
    m0 = miss_seen;
    wait_strw(10, n);
    chk("p0_latency", 32'(n), 32'd4);
    repeat (650) @(posedge clk);
    #1;
    chk("p0_miss_300", 32'(miss_seen - m0 >= 300), 32'd1);
`ifdef DAC_WR_MISS_CNT_EN
    chk("miss_cnt_sat", 32'(miss_cnt_o), 32'hFF);
`endif
    en_i = 1'b0;
    wait_idle(800);

    // round robin: cfg and stream pending together twice
    drive_step();
    period_i  = 16'd20;
    eow_delay = 30;
    en_i      = 1'b1;
    wait_strw(40, n);
    chk("rr_pre_stream", 32'(cfg_ack_o), 32'd0);
    drive_step();
    cfg_data_i = 16'h1234;
    cfg_req_i  = 1'b1;
    wait_strw(60, n);
    chk("rr_first_cfg", 32'(cfg_ack_o), 32'd1);
    chk("rr_first_din", 32'(din_o), 32'h1234);
    drive_step();
    cfg_data_i = 16'h5678;
    wait_strw(60, n);
    chk("rr_second_stream", 32'(cfg_ack_o), 32'd0);
    chk("rr_stream_nib", 32'(din_o[15:12]), 32'h3);
    wait_strw(60, n);
    chk("rr_third_cfg", 32'(cfg_ack_o), 32'd1);
    chk("rr_third_din", 32'(din_o), 32'h5678);
    drive_step();
    cfg_req_i = 1'b0;
    en_i      = 1'b0;
    wait_idle(60);

    // reset in the middle of WAIT
    drive_step();
    cfg_data_i = 16'hBEEF;
    cfg_req_i  = 1'b1;
    eow_delay  = 50;
    wait_strw(10, n);
    drive_step();
    cfg_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_strw", 32'(strw_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_addr", 32'(lut_addr_o), 32'd0);
    chk("midrst_din", 32'(din_o), 32'd0);
    drive_step();
    rst_i = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("stray_eow_idle", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
